// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder with valid/ready handshake
//
// Purpose:
//   WIDTH-bit adder split into STAGES equal segments of SEG = WIDTH/STAGES bits.
//   Each pipeline stage adds one segment using BLOCK-bit lookahead groups. The
//   segment carry is registered into the next stage. The upper operand slices
//   travel with the token and the finished lower sum slices are carried forward.
//   Latency is STAGES cycles and throughput is one result per cycle.
//
// Parameters:
//   WIDTH   operand/sum width (default 16)
//   STAGES  pipeline stages = segments = latency, >= 1 (default 2)
//   BLOCK   lookahead group width; WIDTH % (STAGES*BLOCK) == 0 (default 4)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands accepted this cycle
//   a, b       in   WIDTH-bit operands
//   cin        in   carry in
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   z          out  a+b+cin modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow
//
// Configuration:
//   CLA_OVF_EN  when defined, the operand sign bits ride with each token and a
//               registered signed-overflow flag drives ovf. When undefined,
//               ovf is tied to 0 and no sign registers exist.

module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;
  localparam int LAST = STAGES - 1;

  // One segment of carry-lookahead addition. Returns {carry_out, sum}.
  // Every carry (group and bit level) is an explicit sum of products of
  // generate/propagate terms, so no carry depends on a neighbouring carry.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0]  g;
    logic [SEG-1:0]  p;
    logic [SEG-1:0]  c;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   gc;
    logic            t;
    g = x & y;
    p = x ^ y;
    // Group generate / propagate.
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        t = g[j*BLOCK+i];
        for (int n = i + 1; n < BLOCK; n++) t = t & p[j*BLOCK+n];
        gg[j] = gg[j] | t;
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    // Group carries: C[j] = P[j-1..0]&ci | OR_m G[m]&P[j-1..m+1].
    for (int j = 0; j <= NGRP; j++) begin
      t = ci;
      for (int n = 0; n < j; n++) t = t & gp[n];
      gc[j] = t;
      for (int m = 0; m < j; m++) begin
        t = gg[m];
        for (int n = m + 1; n < j; n++) t = t & gp[n];
        gc[j] = gc[j] | t;
      end
    end
    // Bit carries inside each group, from that group's incoming carry.
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        t = gc[j];
        for (int n = 0; n < i; n++) t = t & p[j*BLOCK+n];
        c[j*BLOCK+i] = t;
        for (int m = 0; m < i; m++) begin
          t = g[j*BLOCK+m];
          for (int n = m + 1; n < i; n++) t = t & p[j*BLOCK+n];
          c[j*BLOCK+i] = c[j*BLOCK+i] | t;
        end
      end
    end
    return {gc[NGRP], p ^ c};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k*SEG;  // operand bits still unsummed on entry
    localparam int OW = IW - SEG;       // operand bits handed to the next stage
    localparam int SW = (k + 1) * SEG;  // sum bits complete after this stage

    logic [IW-1:0] ai;
    logic [IW-1:0] bi;
    logic          ci;
    logic          vi;
    logic [SEG:0]  r;
    logic [SW-1:0] sd;
    logic          adv;
    logic          vq;
    logic          cq;
    logic [SW-1:0] sq;

    if (k == 0) begin : g_src
      assign ai = a;
      assign bi = b;
      assign ci = cin;
      assign vi = in_valid;
      assign sd = r[SEG-1:0];
    end else begin : g_chain
      assign ai = g_st[k-1].g_ops.aq;
      assign bi = g_st[k-1].g_ops.bq;
      assign ci = g_st[k-1].cq;
      assign vi = g_st[k-1].vq;
      assign sd = {r[SEG-1:0], g_st[k-1].sq};
    end

    assign r = cla_seg(ai[SEG-1:0], bi[SEG-1:0], ci);

    // A stage may load when it is empty or its contents move on this cycle.
    if (k == LAST) begin : g_tail
      assign adv = ~vq | out_ready;
    end else begin : g_mid
      assign adv = ~vq | g_st[k+1].adv;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vq <= 1'b0;
        cq <= 1'b0;
        sq <= '0;
      end else if (adv) begin
        vq <= vi;
        // Data only moves with a real token, so a bubble leaves the last
        // result visible and quiet.
        if (vi) begin
          cq <= r[SEG];
          sq <= sd;
        end
      end
    end

    if (OW > 0) begin : g_ops
      logic [OW-1:0] aq;
      logic [OW-1:0] bq;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          aq <= '0;
          bq <= '0;
        end else if (adv && vi) begin
          aq <= ai[IW-1:SEG];
          bq <= bi[IW-1:SEG];
        end
      end
    end

`ifdef CLA_OVF_EN
    logic sai;
    logic sbi;
    if (k == 0) begin : g_sgn_src
      assign sai = a[WIDTH-1];
      assign sbi = b[WIDTH-1];
    end else begin : g_sgn_chain
      assign sai = g_st[k-1].g_sgn.saq;
      assign sbi = g_st[k-1].g_sgn.sbq;
    end

    if (k < LAST) begin : g_sgn
      logic saq;
      logic sbq;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          saq <= 1'b0;
          sbq <= 1'b0;
        end else if (adv && vi) begin
          saq <= sai;
          sbq <= sbi;
        end
      end
    end else begin : g_ovf
      logic ovfq;
      // Overflow: like-signed operands whose sum has the other sign.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ovfq <= 1'b0;
        end else if (adv && vi) begin
          ovfq <= (sai == sbi) & (sd[WIDTH-1] != sai);
        end
      end
    end
`endif
  end

  assign in_ready  = g_st[0].adv;
  assign out_valid = g_st[LAST].vq;
  assign z         = g_st[LAST].sq;
  assign cout      = g_st[LAST].cq;

`ifdef CLA_OVF_EN
  assign ovf = g_st[LAST].g_ovf.ovfq;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed self-checking bench for cla_pipe_adder

module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic        cout;
  logic        ovf;

`ifdef CLA_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  cla_pipe_adder #(.WIDTH(16), .STAGES(2), .BLOCK(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [16:0] sb_q[$];

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic        vc [6];
  logic [15:0] vz [6];
  logic        vco[6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
  endtask

  // One clock: drive, record transfers about to happen, then step the clock.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic ordy, input logic [15:0] ez,
                       input logic ec, output logic acc, output logic rdy);
    logic [16:0] e;
    drive(iv, ia, ib, ic, ordy);
    #1;
    rdy = in_ready;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", out_valid, 0);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        check("sb_z", z, e[15:0]);
        check("sb_cout", cout, e[16]);
      end
    end
    if (acc) sb_q.push_back({ec, ez});
    tick();
  endtask

  task automatic drain(input string tag);
    logic acc;
    logic rdy;
    for (int n = 0; n < 20 && sb_q.size() > 0; n++)
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, acc, rdy);
    check(tag, sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic rdy;
    int   ptr;
    int   pop0;

    va[0] = 16'h1234; vb[0] = 16'h1111; vc[0] = 1'b0; vz[0] = 16'h2345; vco[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; vz[1] = 16'h0000; vco[1] = 1'b1;
    va[2] = 16'h0F0F; vb[2] = 16'h00F1; vc[2] = 1'b0; vz[2] = 16'h1000; vco[2] = 1'b0;
    va[3] = 16'hABCD; vb[3] = 16'h0000; vc[3] = 1'b1; vz[3] = 16'hABCE; vco[3] = 1'b0;
    va[4] = 16'hFFFE; vb[4] = 16'h0001; vc[4] = 1'b1; vz[4] = 16'h0000; vco[4] = 1'b1;
    va[5] = 16'h00FF; vb[5] = 16'h0000; vc[5] = 1'b1; vz[5] = 16'h0100; vco[5] = 1'b0;

    // Reset state
    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // 1: single add, latency 2
    drive(1'b1, 16'h000A, 16'h000B, 1'b0, 1'b1);
    #1;
    check("t1_in_ready", in_ready, 1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("t1_lat1_valid", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_z", z, 16'h0015);
    check("t1_cout", cout, 0);
    tick();
    check("t1_gone", out_valid, 0);

    // 2: carries across the segment boundary and full wrap-around
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, acc, rdy);
    check("t2_acc0", acc, 1);
    cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, acc, rdy);
    check("t2_acc1", acc, 1);
    cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, acc, rdy);
    check("t2_acc2", acc, 1);
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, acc, rdy);
    check("t2_acc3", acc, 1);
    cycle(1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b1, acc, rdy);
    check("t2_acc4", acc, 1);
    cycle(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h1010, 1'b0, acc, rdy);
    check("t2_acc5", acc, 1);
    drain("t2_drain");

    // 3: back-to-back stream, results on consecutive cycles
    drive(1'b1, 16'd12, 16'd2, 1'b0, 1'b1);
    tick();
    check("t3_pre_valid", out_valid, 0);
    drive(1'b1, 16'd9, 16'd16, 1'b0, 1'b1);
    tick();
    check("t3_v0", out_valid, 1);
    check("t3_z0", z, 16'd14);
    drive(1'b1, 16'd2, 16'd8, 1'b0, 1'b1);
    tick();
    check("t3_v1", out_valid, 1);
    check("t3_z1", z, 16'd25);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick();
    check("t3_v2", out_valid, 1);
    check("t3_z2", z, 16'd10);
    tick();
    check("t3_end", out_valid, 0);

    // 4: back-pressure for 5 cycles, then release
    ptr  = 0;
    pop0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, va[ptr], vb[ptr], vc[ptr], 1'b0, vz[ptr], vco[ptr], acc, rdy);
      check("t4_in_ready", rdy, (i < 2) ? 1 : 0);
      if (acc) ptr++;
      if (i >= 1) begin
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_z", z, 16'h2345);
      end
    end
    check("t4_accepted", ptr, 2);
    for (int n = 0; n < 30 && (ptr < 6 || sb_q.size() > 0); n++) begin
      if (ptr < 6) begin
        cycle(1'b1, va[ptr], vb[ptr], vc[ptr], 1'b1, vz[ptr], vco[ptr], acc, rdy);
        if (acc) ptr++;
      end else begin
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, acc, rdy);
      end
    end
    check("t4_sent", ptr, 6);
    check("t4_left", sb_q.size(), 0);
    check("t4_popped", n_pop - pop0, 6);

    // 5: reset with two tokens in flight
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_z", z, 16'h0303);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_z", z, 0);
    check("t5_rst_cout", cout, 0);
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_quiet", out_valid, 0);
    end

    // 6: signed overflow
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("t6a_valid", out_valid, 1);
    check("t6a_z", z, 16'h8000);
    check("t6a_cout", cout, 0);
    check("t6a_ovf", ovf, OVF_ON);
    tick();
    check("t6b_valid", out_valid, 1);
    check("t6b_z", z, 16'h0000);
    check("t6b_cout", cout, 1);
    check("t6b_ovf", ovf, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
